// File: rtl/mlp_dot_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mlp_dot_stream : streaming bf16 dot product on a cascaded-MLP pipeline  (rev 1.0)
// ----------------------------------------------------------------------------
module mlp_dot_stream #(
  parameter int NUM_MLP    = 4,
  parameter int OUT_FP24   = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [32*NUM_MLP-1:0]                  i_a,
  input  logic [32*NUM_MLP-1:0]                  i_b,
  input  logic                                   i_first,
  input  logic                                   i_last,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic [((OUT_FP24 != 0) ? 24 : 16)-1:0] o_sum,
  output logic [CNT_W-1:0]                       o_beats,
  output logic                                   o_proto_err
);
  localparam int SUM_W = (OUT_FP24 != 0) ? 24 : 16;
  localparam int L     = NUM_MLP + 6;
  localparam int PAD   = L - 1 - NUM_MLP;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CRW   = $clog2(FIFO_DEPTH + 1);

  // bf16 x bf16 -> fp24 is exact; denormals flush to zero, overflow clamps to max finite.
  function automatic logic [23:0] fp_mul(input logic [15:0] x, input logic [15:0] y);
    logic [15:0]       p;
    logic signed [9:0] e;
    logic              s;
    s = x[15] ^ y[15];
    p = 16'({1'b1, x[6:0]}) * 16'({1'b1, y[6:0]});
    e = $signed({2'b0, x[14:7]}) + $signed({2'b0, y[14:7]}) - 10'sd127 + (p[15] ? 10'sd1 : 10'sd0);
    if (x[14:7] == 8'd0 || y[14:7] == 8'd0 || e <= 10'sd0) return {s, 23'd0};
    if (e >= 10'sd255) return {s, 8'hFE, 15'h7FFF};
    return {s, e[7:0], p[15] ? p[14:0] : {p[13:0], 1'b0}};
  endfunction

  // fp24 (e8m15) add, round to nearest even using guard/round/sticky bits.
  function automatic logic [23:0] fp_add(input logic [23:0] x, input logic [23:0] y);
    logic [23:0]       hi, lo;
    logic [7:0]        d;
    logic [19:0]       mh, ml, s;
    logic signed [9:0] e;
    logic [15:0]       m;
    logic              up;
    if (x[22:15] == 8'd0) return y;
    if (y[22:15] == 8'd0) return x;
    if (x[22:0] >= y[22:0]) begin hi = x; lo = y; end
    else begin hi = y; lo = x; end
    d  = hi[22:15] - lo[22:15];
    mh = {2'b01, hi[14:0], 3'b000};
    ml = {2'b01, lo[14:0], 3'b000};
    if (d > 8'd18) ml = 20'd1;
    else if (d != 8'd0) ml = (ml >> d) | {19'd0, |(ml & ~(20'hFFFFF << d))};
    e = $signed({2'b0, hi[22:15]});
    s = (hi[23] == lo[23]) ? mh + ml : mh - ml;
    if (s == 20'd0) return 24'd0;
    if (s[19]) begin
      s = {1'b0, s[19:2], s[1] | s[0]};
      e = e + 10'sd1;
    end
    for (int i = 0; i < 18; i++) begin
      if (!s[18]) begin
        s = s << 1;
        e = e - 10'sd1;
      end
    end
    up = s[2] & (s[3] | s[1] | s[0]);
    m  = {1'b0, s[17:3]} + {15'd0, up};
    if (m[15]) e = e + 10'sd1;
    if (e <= 10'sd0) return {hi[23], 23'd0};
    if (e >= 10'sd255) return {hi[23], 8'hFE, 15'h7FFF};
    return {hi[23], e[7:0], m[14:0]};
  endfunction

  function automatic logic [15:0] to_bf16(input logic [23:0] x);
    logic [14:0] r;
    r = x[22:8] + {14'd0, x[7] & ((|x[6:0]) | x[8])};
    return (x[22:15] == 8'd0) ? {x[23], 15'd0} : {x[23], r};
  endfunction

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t           r_state, w_nstate;
  logic [CNT_W-1:0] r_beats, w_nbeats, w_qbeats, w_inc;
  logic             r_err, w_err, w_queue, w_acc;
  logic [CRW-1:0]   r_cred;
  logic             w_pop, w_ld, w_wr;

  assign w_acc   = i_valid & o_ready;
  assign o_ready = (r_cred != '0);
  assign w_inc   = (r_beats == '1) ? r_beats : r_beats + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_beats <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_beats <= w_nbeats;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nbeats = r_beats;
    w_qbeats = w_inc;
    w_queue  = 1'b0;
    w_err    = 1'b0;
    if (w_acc) begin
      if (i_first) begin
        w_err    = (r_state == S_ACCUM);
        w_nbeats = CNT_W'(1);
        w_qbeats = CNT_W'(1);
        w_queue  = i_last;
        w_nstate = i_last ? S_IDLE : S_ACCUM;
      end else if (r_state == S_IDLE) begin
        w_err = 1'b1;
      end else begin
        w_nbeats = w_inc;
        w_queue  = i_last;
        if (i_last) w_nstate = S_IDLE;
      end
    end
  end
  assign o_proto_err = r_err;

  // Load flag reaches the accumulating (last) stage NUM_MLP-1 cycles after the input register.
  logic [NUM_MLP-1:0] r_ldp;
  always_ff @(posedge i_clk) r_ldp <= {r_ldp[NUM_MLP-2:0], w_acc & i_first};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MLP; gi++) begin : g_stage
      logic [63:0] r_dl [0:gi];
      logic [23:0] w_ab, w_cin, w_part, r_casc;
      always_ff @(posedge i_clk) begin
        r_dl[0] <= w_acc ? {i_a[32*gi +: 32], i_b[32*gi +: 32]} : 64'd0;
        for (int k = 1; k <= gi; k++) r_dl[k] <= r_dl[k-1];
      end
      assign w_ab = fp_add(fp_mul(r_dl[gi][47:32], r_dl[gi][15:0]),
                           fp_mul(r_dl[gi][63:48], r_dl[gi][31:16]));
      if (gi == 0) begin : g_head
        assign w_cin = 24'd0;
      end else begin : g_chain
        assign w_cin = g_stage[gi-1].r_casc;
      end
      assign w_part = fp_add(w_cin, w_ab);
      // The last stage keeps r_casc as the running accumulator.
      always_ff @(posedge i_clk) begin
        if (gi == NUM_MLP - 1) r_casc <= r_ldp[NUM_MLP-1] ? w_part : fp_add(r_casc, w_part);
        else                   r_casc <= w_part;
      end
    end
  endgenerate

  logic [23:0]      r_sp [PAD];
  logic [L-1:0]     r_lq;
  logic [CNT_W-1:0] r_lb [L];
  logic [SUM_W-1:0] w_res;

  always_ff @(posedge i_clk) begin
    r_sp[0] <= g_stage[NUM_MLP-1].r_casc;
    for (int k = 1; k < PAD; k++) r_sp[k] <= r_sp[k-1];
    r_lb[0] <= w_qbeats;
    for (int k = 1; k < L; k++) r_lb[k] <= r_lb[k-1];
    if (i_reset) r_lq <= '0;
    else         r_lq <= {r_lq[L-2:0], w_queue};
  end

  generate
    if (OUT_FP24 != 0) begin : g_fp24
      assign w_res = r_sp[PAD-1];
    end else begin : g_bf16
      assign w_res = to_bf16(r_sp[PAD-1]);
    end
  endgenerate

  // Storage FIFO plus a registered head; credits bound the total so nothing overflows.
  logic [SUM_W+CNT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wp, r_rp;
  logic [CRW-1:0]         r_cnt;
  logic                   r_ov;
  logic [SUM_W-1:0]       r_osum;
  logic [CNT_W-1:0]       r_obeats;

  assign w_wr  = r_lq[L-1];
  assign w_pop = r_ov & i_ready;
  assign w_ld  = (r_cnt != '0) && (!r_ov || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= {w_res, r_lb[L-1]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_ov     <= 1'b0;
      r_osum   <= '0;
      r_obeats <= '0;
      r_cred   <= CRW'(FIFO_DEPTH);
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_ld) begin
        {r_osum, r_obeats} <= r_mem[r_rp];
        r_rp <= r_rp + AW'(1);
        r_ov <= 1'b1;
      end else if (w_pop) begin
        r_ov <= 1'b0;
      end
      r_cnt  <= r_cnt + CRW'(w_wr) - CRW'(w_ld);
      r_cred <= r_cred - CRW'(w_queue) + CRW'(w_pop);
    end
  end

  assign o_valid = r_ov;
  assign o_sum   = r_osum;
  assign o_beats = r_obeats;
endmodule
`default_nettype wire

// File: tb/tb_mlp_dot_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mlp_dot_stream : scoreboard bench for mlp_dot_stream  (rev 1.0)
// ----------------------------------------------------------------------------
module tb_mlp_dot_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // 4-MLP bf16 instance
  logic         v4, f4, l4, rdy4;
  logic [127:0] a4, b4;
  logic         o_ready4, o_valid4, o_err4;
  logic [15:0]  o_sum4, o_beats4;

  mlp_dot_stream #(.NUM_MLP(4), .OUT_FP24(0), .FIFO_DEPTH(4), .CNT_W(16)) u_d4 (
    .i_clk(clk), .i_reset(rst), .i_valid(v4), .o_ready(o_ready4),
    .i_a(a4), .i_b(b4), .i_first(f4), .i_last(l4),
    .o_valid(o_valid4), .i_ready(rdy4), .o_sum(o_sum4), .o_beats(o_beats4),
    .o_proto_err(o_err4));

  // 2-MLP fp24 instance
  logic         v2, f2, l2, rdy2;
  logic [63:0]  a2, b2;
  logic         o_ready2, o_valid2, o_err2;
  logic [23:0]  o_sum2;
  logic [15:0]  o_beats2;

  mlp_dot_stream #(.NUM_MLP(2), .OUT_FP24(1), .FIFO_DEPTH(4), .CNT_W(16)) u_d2 (
    .i_clk(clk), .i_reset(rst), .i_valid(v2), .o_ready(o_ready2),
    .i_a(a2), .i_b(b2), .i_first(f2), .i_last(l2),
    .o_valid(o_valid2), .i_ready(rdy2), .o_sum(o_sum2), .o_beats(o_beats2),
    .o_proto_err(o_err2));

  logic [31:0] q4[$];   // {sum16, beats16}
  logic [39:0] q2[$];   // {sum24, beats16}
  int          err_cnt = 0;
  int          acc_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitors: pop the scoreboard whenever the DUT hands over a result.
  logic        hold4 = 1'b0;
  logic [31:0] held4;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      hold4 = 1'b0;
    end else begin
      if (hold4) begin
        n_cmp++;
        if (!o_valid4 || {o_sum4, o_beats4} !== held4) begin
          n_bad++;
          $display("FAIL d4_hold: got valid=%b %h, required valid=1 %h", o_valid4, {o_sum4, o_beats4}, held4);
        end
      end
      hold4 = o_valid4 && !rdy4;
      held4 = {o_sum4, o_beats4};
      if (o_err4) err_cnt++;
      if (o_valid4 && rdy4) begin
        n_cmp++;
        if (q4.size() == 0) begin
          n_bad++;
          $display("FAIL d4_unexpected: got sum=%h beats=%0d, required no result", o_sum4, o_beats4);
        end else begin
          e = q4.pop_front();
          if ({o_sum4, o_beats4} !== e) begin
            n_bad++;
            $display("FAIL d4_result: got sum=%h beats=%0d, required sum=%h beats=%0d",
                     o_sum4, o_beats4, e[31:16], e[15:0]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst && o_valid2 && rdy2) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_bad++;
        $display("FAIL d2_unexpected: got sum=%h beats=%0d, required no result", o_sum2, o_beats2);
      end else begin
        e = q2.pop_front();
        if ({o_sum2, o_beats2} !== e) begin
          n_bad++;
          $display("FAIL d2_result: got sum=%h beats=%0d, required sum=%h beats=%0d",
                   o_sum2, o_beats2, e[39:16], e[15:0]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat4(input logic [15:0] av, input logic [15:0] bv, input logic f, input logic l);
    int t;
    t  = 0;
    a4 = {8{av}}; b4 = {8{bv}}; f4 = f; l4 = l; v4 = 1'b1;
    while (!o_ready4 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL beat4_accept: o_ready got 0 for %0d cycles, required 1", t);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    v4 = 1'b0; f4 = 1'b0; l4 = 1'b0; a4 = '0; b4 = '0;
  endtask

  task automatic drain4();
    int t;
    t = 0;
    while (q4.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain4_left", q4.size(), 0);
    idle(3);
  endtask

  logic [15:0] bv [5] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0};
  logic [15:0] sv [5] = '{16'h4100, 16'h4180, 16'h41C0, 16'h4200, 16'h4220};

  initial begin
    int t, e0, seen;
    rst = 1'b1;
    v4 = 0; f4 = 0; l4 = 0; a4 = '0; b4 = '0; rdy4 = 1'b1;
    v2 = 0; f2 = 0; l2 = 0; a2 = '0; b2 = '0; rdy2 = 1'b1;
    idle(3);
    rst = 1'b0;

    chk("rst_valid",  o_valid4, 0);
    chk("rst_ready",  o_ready4, 1);
    chk("rst_sum",    o_sum4,   0);
    chk("rst_beats",  o_beats4, 0);
    chk("rst_err",    o_err4,   0);
    chk("rst_valid2", o_valid2, 0);

    // T1: one beat, eight 1.0*1.0 products -> 8.0
    beat4(16'h3F80, 16'h3F80, 1'b1, 1'b1);
    q4.push_back({16'h4100, 16'd1});
    t = 0;
    while (!o_valid4 && t < 40) begin @(negedge clk); t++; end
    chk("t1_latency", cyc - acc_cyc, 11);
    drain4();

    // T2: three beats of eight 1.0*2.0 products with bubbles -> 48.0
    beat4(16'h3F80, 16'h4000, 1'b1, 1'b0);
    idle(2);
    beat4(16'h3F80, 16'h4000, 1'b0, 1'b0);
    idle(2);
    beat4(16'h3F80, 16'h4000, 1'b0, 1'b1);
    q4.push_back({16'h4240, 16'd3});
    drain4();

    // T3: backpressure; credits run out after four queued results
    rdy4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat4(16'h3F80, bv[k], 1'b1, 1'b1);
      q4.push_back({sv[k], 16'd1});
    end
    chk("t3_ready_low", o_ready4, 0);
    idle(14);
    chk("t3_head_valid", o_valid4, 1);
    chk("t3_head_sum",   o_sum4,   16'h4100);
    rdy4 = 1'b1;
    beat4(16'h3F80, bv[4], 1'b1, 1'b1);
    q4.push_back({sv[4], 16'd1});
    drain4();

    // T4: protocol errors
    e0 = err_cnt;
    beat4(16'h3F80, 16'h3F80, 1'b0, 1'b1);
    idle(2);
    chk("t4_idle_err", err_cnt - e0, 1);
    beat4(16'h3F80, 16'h4000, 1'b1, 1'b0);
    beat4(16'h3F80, 16'h4000, 1'b0, 1'b0);
    beat4(16'h3F80, 16'h3F80, 1'b1, 1'b0);
    beat4(16'h3F80, 16'h3F80, 1'b0, 1'b1);
    q4.push_back({16'h4180, 16'd2});
    idle(2);
    chk("t4_restart_err", err_cnt - e0, 2);
    drain4();

    // T5: reset while a result is in flight
    beat4(16'h3F80, 16'h3F80, 1'b1, 1'b1);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_ready", o_ready4, 1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid4) seen++;
    end
    chk("t5_no_valid", seen, 0);
    beat4(16'h3F80, 16'h4040, 1'b1, 1'b1);
    q4.push_back({16'h41C0, 16'd1});
    drain4();

    // T6: 2-MLP fp24 output, four 1.0*1.0 products -> 4.0
    a2 = {4{16'h3F80}}; b2 = {4{16'h3F80}}; f2 = 1'b1; l2 = 1'b1; v2 = 1'b1;
    chk("t6_ready", o_ready2, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    v2 = 1'b0; f2 = 1'b0; l2 = 1'b0;
    q2.push_back({24'h408000, 16'd1});
    t = 0;
    while (!o_valid2 && t < 40) begin @(negedge clk); t++; end
    chk("t6_latency", cyc - acc_cyc, 9);
    idle(3);
    chk("t6_left", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end
endmodule
`default_nettype wire
